// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer register block.
package apb_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE   = 1'b0;
  localparam state_t ACCESS = 1'b1;

  localparam int unsigned PROT_PRIV = 0;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage with per-byte write enables and a combinational read port.
// Register 0 is a read-only identification word.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          NumRegs   = 16,
  parameter logic [DataWidth-1:0] IdValue   = '0,
  localparam int unsigned         IdxWidth  = $clog2(NumRegs),
  localparam int unsigned         StrbWidth = DataWidth / 8
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 we,
  input  logic [IdxWidth-1:0]  widx,
  input  logic [DataWidth-1:0] wdata,
  input  logic [StrbWidth-1:0] strb,
  input  logic [IdxWidth-1:0]  ridx,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] regs_q [NumRegs];
  logic [DataWidth-1:0] regs_d [NumRegs];

  // Byte-lane merge of the write data; slot 0 never holds state.
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (strb[b]) begin
          regs_d[widx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          regs_d[widx][8*b +: 8] = regs_q[widx][8*b +: 8];
        end
      end
    end else begin
      regs_d = regs_q;
    end
    regs_d[0] = '0;
  end

  // Register storage.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata = (ridx == '0) ? IdValue : regs_q[ridx];

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer: setup/access FSM with programmable wait states, address
// decode and error response in front of a byte-strobed register bank.
module apb_completer_regs
  import apb_pkg::*;
#(
  parameter int unsigned          AddrWidth  = 32,
  parameter int unsigned          DataWidth  = 32,
  parameter int unsigned          NumRegs    = 16,
  parameter logic [AddrWidth-1:0] BaseAddr   = '0,
  parameter int unsigned          WaitStates = 0,
  parameter logic [DataWidth-1:0] IdValue    = 32'hA9B0_0001,
  parameter bit                   PrivWrite  = 1'b0
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic [AddrWidth-1:0]   addr,
  input  logic [3:0]             prot,
  input  logic                   sel,
  input  logic                   enable,
  input  logic                   write,
  input  logic [DataWidth-1:0]   wData,
  input  logic [DataWidth/8-1:0] strb,
  output logic                   ready,
  output logic [DataWidth-1:0]   rData,
  output logic                   slvError
);

  localparam int unsigned          StrbWidth = DataWidth / 8;
  localparam int unsigned          IdxWidth  = $clog2(NumRegs);
  localparam int unsigned          AlignBits = $clog2(StrbWidth);
  localparam logic [AddrWidth-1:0] Span      = AddrWidth'(NumRegs * StrbWidth);
  localparam logic [AddrWidth-1:0] AlignMask = AddrWidth'(StrbWidth - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IdxWidth-1:0]    idx_q, idx_d;
  logic                   write_q, write_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [StrbWidth-1:0]   strb_q, strb_d;
  logic                   err_q, err_d;
  logic                   ready_q, ready_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   slverr_q, slverr_d;

  logic [AddrWidth-1:0]   offset_s;
  logic [IdxWidth-1:0]    idx_s;
  logic [IdxWidth-1:0]    ridx_s;
  logic                   setup_err_s;
  logic [DataWidth-1:0]   bank_rdata_s;
  logic                   we_s;
  logic                   unused_prot_s;

  // Decode is evaluated on the live bus during setup; only its result is kept.
  assign offset_s    = addr - BaseAddr;
  assign idx_s       = IdxWidth'(offset_s >> AlignBits);
  assign setup_err_s = (offset_s >= Span) || ((addr & AlignMask) != '0) ||
                       (write && (idx_s == '0)) ||
                       (PrivWrite && write && !prot[PROT_PRIV]);
  assign unused_prot_s = ^prot[3:1];

  assign ridx_s = (state_q == IDLE) ? idx_s : idx_q;
  assign we_s   = (state_q == ACCESS) && sel && enable && ready_q && write_q && !err_q;

  apb_reg_bank #(
    .DataWidth (DataWidth),
    .NumRegs   (NumRegs),
    .IdValue   (IdValue)
  ) u_bank (
    .clk    (clk),
    .nReset (nReset),
    .we     (we_s),
    .widx   (idx_q),
    .wdata  (wdata_q),
    .strb   (strb_q),
    .ridx   (ridx_s),
    .rdata  (bank_rdata_s)
  );

  // Transfer FSM, wait counter and response generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    err_d    = err_q;
    ready_d  = ready_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    case (state_q)
      IDLE: begin
        if (sel && !enable) begin
          idx_d   = idx_s;
          write_d = write;
          wdata_d = wData;
          strb_d  = strb;
          err_d   = setup_err_s;
          cnt_d   = 4'(WaitStates);
          state_d = ACCESS;
          if (WaitStates == 0) begin
            ready_d  = 1'b1;
            slverr_d = setup_err_s ? RESP_ERR : RESP_OKAY;
            rdata_d  = (write || setup_err_s) ? '0 : bank_rdata_s;
          end else begin
            ready_d  = 1'b0;
            slverr_d = RESP_OKAY;
            rdata_d  = '0;
          end
        end else begin
          ready_d  = 1'b0;
          slverr_d = RESP_OKAY;
          rdata_d  = '0;
        end
      end
      ACCESS: begin
        if (!sel) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          slverr_d = RESP_OKAY;
          rdata_d  = '0;
        end else if (ready_q) begin
          if (enable) begin
            state_d  = IDLE;
            ready_d  = 1'b0;
            slverr_d = RESP_OKAY;
            rdata_d  = '0;
          end else begin
            state_d  = ACCESS;
          end
        end else if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Last wait cycle: response becomes visible in the next cycle.
          cnt_d    = 4'd0;
          ready_d  = 1'b1;
          slverr_d = err_q ? RESP_ERR : RESP_OKAY;
          rdata_d  = (write_q || err_q) ? '0 : bank_rdata_s;
        end
      end
      default: begin
        state_d  = IDLE;
        ready_d  = 1'b0;
        slverr_d = RESP_OKAY;
        rdata_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
    end
  end

  assign ready    = ready_q;
  assign rData    = rdata_q;
  assign slvError = slverr_q;

endmodule

// File: tb/tb_apb_completer_regs.sv
// Directed bench: four completer instances (0: no waits, 1: 3 waits,
// 2: 2 waits, 3: privileged writes) sharing one bus with separate selects.
module tb_apb_completer_regs;

  logic        clk;
  logic        nReset;
  logic [31:0] addr;
  logic [3:0]  prot;
  logic [3:0]  sel;
  logic        enable;
  logic        write;
  logic [31:0] wData;
  logic [3:0]  strb;
  logic [3:0]  rdy;
  logic [3:0]  err;
  logic [31:0] rdat [4];

  int tests = 0;
  int fails = 0;

  apb_completer_regs #(.WaitStates(0)) u_dut0 (
    .clk(clk), .nReset(nReset), .addr(addr), .prot(prot), .sel(sel[0]), .enable(enable),
    .write(write), .wData(wData), .strb(strb), .ready(rdy[0]), .rData(rdat[0]), .slvError(err[0]));
  apb_completer_regs #(.WaitStates(3)) u_dut1 (
    .clk(clk), .nReset(nReset), .addr(addr), .prot(prot), .sel(sel[1]), .enable(enable),
    .write(write), .wData(wData), .strb(strb), .ready(rdy[1]), .rData(rdat[1]), .slvError(err[1]));
  apb_completer_regs #(.WaitStates(2)) u_dut2 (
    .clk(clk), .nReset(nReset), .addr(addr), .prot(prot), .sel(sel[2]), .enable(enable),
    .write(write), .wData(wData), .strb(strb), .ready(rdy[2]), .rData(rdat[2]), .slvError(err[2]));
  apb_completer_regs #(.WaitStates(0), .PrivWrite(1'b1)) u_dut3 (
    .clk(clk), .nReset(nReset), .addr(addr), .prot(prot), .sel(sel[3]), .enable(enable),
    .write(write), .wData(wData), .strb(strb), .ready(rdy[3]), .rData(rdat[3]), .slvError(err[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One full transfer; called at a falling edge, returns at the falling edge after completion.
  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [3:0] p,
                      output logic [31:0] rd, output logic er, output int waits);
    sel[k] = 1'b1; enable = 1'b0; write = w; addr = a; wData = d; strb = s; prot = p;
    @(negedge clk);
    enable = 1'b1;
    waits = 0;
    while (rdy[k] !== 1'b1 && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    tests++;
    if (rdy[k] !== 1'b1) begin
      fails++;
      $display("FAIL xfer_timeout dut=%0d addr=%h ready=%b expected 1", k, a, rdy[k]);
    end
    rd = rdat[k];
    er = err[k];
    @(negedge clk);
    sel[k] = 1'b0; enable = 1'b0;
  endtask

  task automatic test_reset();
    nReset = 1'b0; sel = 4'h0; enable = 1'b0; write = 1'b0;
    addr = 32'h0; wData = 32'h0; strb = 4'h0; prot = 4'h0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (rdy[k] !== 1'b0 || err[k] !== 1'b0 || rdat[k] !== 32'h0) begin
        fails++;
        $display("FAIL reset_outputs dut=%0d got ready=%b err=%b rdata=%h expected 0/0/0", k, rdy[k], err[k], rdat[k]);
      end
    end
    nReset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int w;
    xfer(0, 1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 4'h0, rd, er, w);
    tests++;
    if (w !== 0 || er !== 1'b0 || rd !== 32'h0) begin
      fails++;
      $display("FAIL write_ws0 got waits=%0d err=%b rdata=%h expected 0/0/00000000", w, er, rd);
    end
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 4'h0, rd, er, w);
    tests++;
    if (w !== 0 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL read_back got waits=%0d err=%b rdata=%h expected 0/0/deadbeef", w, er, rd);
    end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic er; int w;
    xfer(0, 1'b1, 32'h8, 32'h1122_3344, 4'hF, 4'h0, rd, er, w);
    xfer(0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'h5, 4'h0, rd, er, w);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, 4'h0, rd, er, w);
    tests++;
    if (rd !== 32'h11BB_33DD || er !== 1'b0) begin
      fails++;
      $display("FAIL partial_strobe got rdata=%h err=%b expected 11bb33dd/0", rd, er);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int w;
    xfer(2, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, rd, er, w);
    tests++;
    if (w !== 2 || er !== 1'b0 || rd !== 32'hA9B0_0001) begin
      fails++;
      $display("FAIL wait2_read_id got waits=%0d err=%b rdata=%h expected 2/0/a9b00001", w, er, rd);
    end
    tests++;
    if (rdy[2] !== 1'b0) begin
      fails++;
      $display("FAIL ready_after_completion got %b expected 0", rdy[2]);
    end
    // Back-to-back write then read, each started in the cycle after completion.
    xfer(2, 1'b1, 32'h3C, 32'h0BAD_F00D, 4'hF, 4'h0, rd, er, w);
    xfer(2, 1'b0, 32'h3C, 32'h0, 4'h0, 4'h0, rd, er, w);
    tests++;
    if (w !== 2 || rd !== 32'h0BAD_F00D) begin
      fails++;
      $display("FAIL back_to_back got waits=%0d rdata=%h expected 2/0badf00d", w, rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int w;
    xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 4'h0, rd, er, w);
    tests++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      fails++;
      $display("FAIL err_out_of_range got err=%b rdata=%h expected 1/00000000", er, rd);
    end
    xfer(0, 1'b1, 32'h2, 32'hFFFF_FFFF, 4'hF, 4'h0, rd, er, w);
    tests++;
    if (er !== 1'b1) begin
      fails++;
      $display("FAIL err_misaligned_write got err=%b expected 1", er);
    end
    xfer(0, 1'b1, 32'h6, 32'hFFFF_FFFF, 4'hF, 4'h0, rd, er, w);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 4'h0, rd, er, w);
    tests++;
    if (er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL errored_write_no_effect got err=%b rdata=%h expected 0/deadbeef", er, rd);
    end
    xfer(0, 1'b1, 32'h0, 32'h5, 4'hF, 4'h0, rd, er, w);
    tests++;
    if (er !== 1'b1) begin
      fails++;
      $display("FAIL err_write_reg0 got err=%b expected 1", er);
    end
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, rd, er, w);
    tests++;
    if (er !== 1'b0 || rd !== 32'hA9B0_0001) begin
      fails++;
      $display("FAIL reg0_still_id got err=%b rdata=%h expected 0/a9b00001", er, rd);
    end
    xfer(0, 1'b0, 32'h3C, 32'h0, 4'h0, 4'h0, rd, er, w);
    tests++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      fails++;
      $display("FAIL last_reg_in_range got err=%b rdata=%h expected 0/00000000", er, rd);
    end
  endtask

  task automatic test_priv_write();
    logic [31:0] rd; logic er; int w;
    xfer(3, 1'b1, 32'h4, 32'h1234_5678, 4'hF, 4'h0, rd, er, w);
    tests++;
    if (er !== 1'b1) begin
      fails++;
      $display("FAIL priv_unpriv_write got err=%b expected 1", er);
    end
    xfer(3, 1'b0, 32'h4, 32'h0, 4'h0, 4'h0, rd, er, w);
    tests++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      fails++;
      $display("FAIL priv_reg_unchanged got err=%b rdata=%h expected 0/00000000", er, rd);
    end
    xfer(3, 1'b1, 32'h4, 32'hCAFE_F00D, 4'hF, 4'h1, rd, er, w);
    xfer(3, 1'b0, 32'h4, 32'h0, 4'h0, 4'h0, rd, er, w);
    tests++;
    if (er !== 1'b0 || rd !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL priv_write_ok got err=%b rdata=%h expected 0/cafef00d", er, rd);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int w; int seen;
    seen = 0;
    sel[1] = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h8; wData = 32'h5555_5555; strb = 4'hF;
    @(negedge clk);
    enable = 1'b1;
    if (rdy[1] === 1'b1) seen++;
    @(negedge clk);
    if (rdy[1] === 1'b1) seen++;
    sel[1] = 1'b0; enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rdy[1] === 1'b1) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL abort_no_ready got %0d ready cycles expected 0", seen);
    end
    xfer(1, 1'b0, 32'h8, 32'h0, 4'h0, 4'h0, rd, er, w);
    tests++;
    if (w !== 3 || er !== 1'b0 || rd !== 32'h0) begin
      fails++;
      $display("FAIL after_abort_read got waits=%0d err=%b rdata=%h expected 3/0/00000000", w, er, rd);
    end
  endtask

  task automatic test_no_setup();
    logic [31:0] rd; logic er; int w; int seen;
    seen = 0;
    sel[0] = 1'b1; enable = 1'b1; write = 1'b1; addr = 32'h4; wData = 32'h0; strb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rdy[0] === 1'b1) seen++;
    end
    sel[0] = 1'b0; enable = 1'b0;
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL enable_without_setup got %0d ready cycles expected 0", seen);
    end
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 4'h0, rd, er, w);
    tests++;
    if (rd !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL no_setup_no_write got rdata=%h expected deadbeef", rd);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic er; int w; int n;
    sel[1] = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'hC; wData = 32'h1234_5678; strb = 4'hF;
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (rdy[1] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== 3) begin
      fails++;
      $display("FAIL mid_reset_waits got %0d expected 3", n);
    end
    nReset = 1'b0;
    #1;
    tests++;
    if (rdy[1] !== 1'b0 || err[1] !== 1'b0 || rdat[1] !== 32'h0) begin
      fails++;
      $display("FAIL async_reset_outputs got ready=%b err=%b rdata=%h expected 0/0/0", rdy[1], err[1], rdat[1]);
    end
    @(negedge clk);
    sel[1] = 1'b0; enable = 1'b0;
    nReset = 1'b1;
    @(negedge clk);
    xfer(1, 1'b0, 32'hC, 32'h0, 4'h0, 4'h0, rd, er, w);
    tests++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      fails++;
      $display("FAIL reset_lost_write got err=%b rdata=%h expected 0/00000000", er, rd);
    end
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 4'h0, rd, er, w);
    tests++;
    if (rd !== 32'h0) begin
      fails++;
      $display("FAIL reset_clears_regs got rdata=%h expected 00000000", rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_wait_states();
    test_errors();
    test_priv_write();
    test_abort();
    test_no_setup();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
